// File: rtl/bubble_sorter_pkg.sv
// Shared types and sizing helpers for the bubble sorter.
package bubble_sorter_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam int DEF_DEPTH = 4;

  // Worst-case number of compare cycles for a job of the given depth.
  function automatic int max_cmp(input int depth);
    return depth * (depth - 1) / 2;
  endfunction

  localparam int IDX_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = $clog2(max_cmp(DEF_DEPTH) + 1);

endpackage

// File: rtl/bsort_cmp_swap.sv
// Combinational compare-swap of one adjacent pair; equal words keep their order.
module bsort_cmp_swap #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              swap
);
  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/bubble_sorter.sv
// In-place bubble sort engine: load DEPTH words, one compare-swap per clock, drain ascending.
// Optional swap counter port enabled by defining SWAP_CNT_EN.
module bubble_sorter
  import bubble_sorter_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int DATA_W   = 4,
  localparam int IDX_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = $clog2(max_cmp(DEPTH) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
`ifdef SWAP_CNT_EN
  ,
  output logic [CNT_BITS-1:0] swap_cnt
`endif
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);
  localparam logic [IDX_BITS-1:0] LAST_CMP = IDX_BITS'(DEPTH - 2);

  state_t state, state_nxt;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [IDX_BITS-1:0] wr_idx, rd_idx, cmp_idx, cmp_nxt, pass;
  logic pass_swap;
  logic [DATA_W-1:0] lo, hi;
  logic swap, pass_end, sort_done, load_done;

  assign cmp_nxt   = cmp_idx + IDX_BITS'(1);
  // Pass p ends at pair index DEPTH-2-p; the tail above it is already in place.
  assign pass_end  = cmp_idx == (LAST_CMP - pass);
  assign sort_done = (!pass_swap && !swap) || (pass == LAST_CMP);
  assign load_done = in_valid && (wr_idx == LAST_IDX);

  bsort_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
    .a    (mem[cmp_idx]),
    .b    (mem[cmp_nxt]),
    .lo   (lo),
    .hi   (hi),
    .swap (swap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (load_done) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (pass_end && sort_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        out_last  = rd_idx == LAST_IDX;
        if (out_ready && out_last) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      cmp_idx   <= '0;
      pass      <= '0;
      pass_swap <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          mem[wr_idx] <= in_data;
          if (wr_idx == LAST_IDX) begin
            wr_idx    <= '0;
            cmp_idx   <= '0;
            pass      <= '0;
            pass_swap <= 1'b0;
          end else begin
            wr_idx <= wr_idx + IDX_BITS'(1);
          end
        end
        SORT: begin
          if (swap) begin
            mem[cmp_idx] <= lo;
            mem[cmp_nxt] <= hi;
          end
          if (pass_end) begin
            cmp_idx   <= '0;
            pass_swap <= 1'b0;
            if (sort_done) rd_idx <= '0;
            else           pass   <= pass + IDX_BITS'(1);
          end else begin
            cmp_idx   <= cmp_nxt;
            pass_swap <= pass_swap | swap;
          end
        end
        DRAIN: if (out_ready) begin
          if (rd_idx == LAST_IDX) rd_idx <= '0;
          else                    rd_idx <= rd_idx + IDX_BITS'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SWAP_CNT_EN
  // Cleared on SORT entry, then held until the next job starts sorting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             swap_cnt <= '0;
    else if (state == LOAD && load_done) swap_cnt <= '0;
    else if (state == SORT && swap)      swap_cnt <= swap_cnt + CNT_BITS'(1);
  end
`endif

endmodule
